binary_game_ctrl: RTL

- Parametrised successor to the fixed 4-bit game logic, timer and generator trio.
- One block holds the game state machine, a per-level countdown timer with prescaler, a no-repeat pseudo-random target generator, the comparator, and lives/level bookkeeping.
- Sits between the debounced button/switch inputs and the LCD display driver, which consumes state, target, level, time_left and lives.

---
 rtl/binary_game_ctrl_pkg.sv | 20 ++
 rtl/binary_game_ctrl_if.sv | 27 ++
 rtl/binary_game_ctrl_lfsr.sv | 19 +
 rtl/binary_game_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/binary_game_ctrl_pkg.sv
// binary_game_ctrl_pkg: shared state encoding, LFSR constants and round-time helper.
package binary_game_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;
    localparam logic [1:0] ST_OVER   = 2'd3;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic longint unsigned alloc_time(input longint unsigned lvl, input longint unsigned base,
                                                   input longint unsigned step, input longint unsigned min_t);
        longint unsigned t;
        t = (lvl * step >= base) ? 64'd0 : base - lvl * step;
        return (t < min_t) ? min_t : t;
    endfunction

endpackage

// File: rtl/binary_game_ctrl_if.sv
// binary_game_ctrl_if: button/switch inputs and display-facing game status.
interface binary_game_ctrl_if #(
    parameter int NUM_W   = 4,
    parameter int LEVEL_W = 8,
    parameter int TIME_W  = 5
);
    logic               start;
    logic               guess_valid;
    logic [NUM_W-1:0]   guess;
    logic [1:0]         state;
    logic [NUM_W-1:0]   target;
    logic [LEVEL_W-1:0] level;
    logic [TIME_W-1:0]  time_left;
    logic [2:0]         lives;
    logic               hit;
    logic               miss;

    modport master (
        output start, guess_valid, guess,
        input  state, target, level, time_left, lives, hit, miss
    );

    modport slave (
        input  start, guess_valid, guess,
        output state, target, level, time_left, lives, hit, miss
    );
endinterface

// File: rtl/binary_game_ctrl_lfsr.sv
// game_lfsr: free-running 16-bit Galois LFSR; a non-zero seed keeps it off the all-zero lockup.
module game_lfsr
    import binary_game_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_value
);
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= SEED;
        else     r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign o_value = r_lfsr;
endmodule

// File: rtl/binary_game_ctrl.sv
// binary_game_ctrl: guessing-game FSM with per-level countdown, no-repeat targets and lives/level tracking.
module binary_game_ctrl
    import binary_game_ctrl_pkg::*;
#(
    parameter int          NUM_W      = 4,
    parameter int          LEVEL_W    = 8,
    parameter int          TIME_W     = 5,
    parameter int          TICK_DIV   = 50000000,
    parameter int          BASE_TIME  = 20,
    parameter int          TIME_STEP  = 1,
    parameter int          MIN_TIME   = 5,
    parameter int          LIVES      = 3,
    parameter int          RESULT_CYC = 16,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input logic               clk,
    input logic               rst,
    binary_game_ctrl_if.slave bus
);
    localparam int          P_W   = $clog2(TICK_DIV);
    localparam int          RC_W  = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
    localparam logic [63:0] T_MAX = (64'd1 << TIME_W) - 64'd1;

    logic [1:0]         r_state;
    logic [NUM_W-1:0]   r_target;
    logic [LEVEL_W-1:0] r_level;
    logic [TIME_W-1:0]  r_time;
    logic [2:0]         r_lives;
    logic               r_hit;
    logic               r_miss;
    logic [P_W-1:0]     r_presc;
    logic [RC_W-1:0]    r_rcnt;

    logic [15:0]        w_lfsr;
    logic               w_unused;
    logic [NUM_W-1:0]   w_cand;
    logic [NUM_W-1:0]   w_new_tgt;
    logic [63:0]        w_alloc_lvl;
    logic [63:0]        w_alloc_zero;
    logic [TIME_W-1:0]  w_alloc;
    logic [TIME_W-1:0]  w_alloc0;
    logic               w_play;
    logic               w_tick;
    logic               w_correct;
    logic               w_wrong;
    logic               w_timeout;
    logic               w_begin;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_value (w_lfsr)
    );

    assign w_unused     = ^w_lfsr;
    assign w_cand       = w_lfsr[NUM_W-1:0];
    assign w_new_tgt    = (w_cand == r_target) ? w_cand ^ NUM_W'(1) : w_cand;
    assign w_alloc_lvl  = alloc_time(64'(r_level), 64'(BASE_TIME), 64'(TIME_STEP), 64'(MIN_TIME));
    assign w_alloc_zero = alloc_time(64'd0, 64'(BASE_TIME), 64'(TIME_STEP), 64'(MIN_TIME));
    assign w_alloc      = (w_alloc_lvl > T_MAX) ? TIME_W'(T_MAX) : w_alloc_lvl[TIME_W-1:0];
    assign w_alloc0     = (w_alloc_zero > T_MAX) ? TIME_W'(T_MAX) : w_alloc_zero[TIME_W-1:0];
    assign w_play       = (r_state == ST_PLAY);
    assign w_tick       = w_play && (r_presc == P_W'(TICK_DIV - 1));
    assign w_correct    = bus.guess_valid && (bus.guess == r_target);
    assign w_wrong      = bus.guess_valid && !w_correct;
    assign w_timeout    = w_tick && (r_time == TIME_W'(1));
    assign w_begin      = bus.start && (r_state == ST_IDLE || r_state == ST_OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_level  <= '0;
            r_time   <= '0;
            r_lives  <= 3'(LIVES);
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_presc  <= '0;
            r_rcnt   <= '0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (w_begin) begin
                r_state  <= ST_PLAY;
                r_level  <= '0;
                r_lives  <= 3'(LIVES);
                r_target <= w_new_tgt;
                r_time   <= w_alloc0;
                r_presc  <= '0;
            end else if (w_play) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick && r_time != '0) r_time <= r_time - 1'b1;
                // a correct guess outranks a coincident timeout
                if (w_correct) begin
                    r_hit   <= 1'b1;
                    r_level <= (&r_level) ? r_level : r_level + 1'b1;
                    r_state <= ST_RESULT;
                    r_rcnt  <= '0;
                end else if (w_wrong || w_timeout) begin
                    r_miss  <= 1'b1;
                    r_lives <= r_lives - 1'b1;
                    if (r_lives == 3'd1) begin
                        r_state <= ST_OVER;
                        r_time  <= '0;
                    end else if (w_timeout) begin
                        r_target <= w_new_tgt;
                        r_time   <= w_alloc;
                        r_presc  <= '0;
                    end
                end
            end else if (r_state == ST_RESULT) begin
                if (r_rcnt == RC_W'(RESULT_CYC - 1)) begin
                    r_state  <= ST_PLAY;
                    r_target <= w_new_tgt;
                    r_time   <= w_alloc;
                    r_presc  <= '0;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.target    = r_target;
    assign bus.level     = r_level;
    assign bus.time_left = r_time;
    assign bus.lives     = r_lives;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;
endmodule
